// File: rtl/mul4_sched.sv
// mul4_sched: two-port round-robin scheduler in front of one shared 4x4
// shift-and-add multiplier. A request is captured in IDLE, computed over four
// CALC cycles (one multiplier bit per cycle) and then held in DONE until ack.
module mul4_sched #(
    parameter bit PRIO_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    output logic       gnt0,
    input  logic       req1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       gnt1,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic [7:0] product,
    input  logic       ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [3:0]  mcand;
    logic [3:0]  mplier;
    logic [7:0]  acc;
    logic [1:0]  cnt;
    logic        owner;
    logic        prio;

    logic        any_req;
    logic        win1;

    // Port 1 wins when it is alone, or when both ask and the pointer favours it.
    assign any_req = req0 | req1;
    assign win1    = req1 & (~req0 | prio);

    // State register; reset drops straight back to IDLE, abandoning any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: four CALC cycles, then DONE holds until ack.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (any_req) next_state = CALC;
            CALC: if (cnt == 2'd3) next_state = DONE;
            DONE: if (ack) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Shared datapath: operand capture, one shift-and-add step per CALC cycle,
    // and the round-robin pointer moving away from the port just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= 4'd0;
            mplier <= 4'd0;
            acc    <= 8'd0;
            cnt    <= 2'd0;
            owner  <= 1'b0;
            prio   <= PRIO_INIT;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        mcand  <= win1 ? a1 : a0;
                        mplier <= win1 ? b1 : b0;
                        acc    <= 8'd0;
                        cnt    <= 2'd0;
                        owner  <= win1;
                    end
                end
                CALC: begin
                    if (mplier[cnt]) begin
                        acc <= acc + (8'(mcand) << cnt);
                    end
                    cnt <= cnt + 2'd1;
                end
                DONE: begin
                    if (ack) begin
                        prio <= ~owner;
                    end
                end
                default: begin
                    cnt <= 2'd0;
                end
            endcase
        end
    end

    // Outputs: grant only in the first CALC cycle, result visible only in DONE.
    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        gnt0    = (state == CALC) && (cnt == 2'd0) && !owner;
        gnt1    = (state == CALC) && (cnt == 2'd0) && owner;
        done_id = done & owner;
        product = done ? acc : 8'd0;
    end

endmodule

// File: tb/tb_mul4_sched.sv
// tb_mul4_sched: directed bench for mul4_sched with hand-computed products.
module tb_mul4_sched;

    logic       clk;
    logic       rst_n;
    logic       req0;
    logic [3:0] a0;
    logic [3:0] b0;
    logic       gnt0;
    logic       req1;
    logic [3:0] a1;
    logic [3:0] b1;
    logic       gnt1;
    logic       busy;
    logic       done;
    logic       done_id;
    logic [7:0] product;
    logic       ack;

    int checks   = 0;
    int failures = 0;

    mul4_sched #(.PRIO_INIT(1'b0)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .gnt0    (gnt0),
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .product (product),
        .ack     (ack)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, " busy"},    busy,    8'd0);
        check_output({tag, " done"},    done,    8'd0);
        check_output({tag, " product"}, product, 8'd0);
        check_output({tag, " gnt0"},    gnt0,    8'd0);
        check_output({tag, " gnt1"},    gnt1,    8'd0);
        check_output({tag, " done_id"}, done_id, 8'd0);
    endtask

    // Drive one request on port p, follow it through CALC and DONE, then ack.
    // With stray set, ack is raised during the middle CALC cycles.
    task automatic apply_stimulus(input bit p, input logic [3:0] a, input logic [3:0] b,
                                  input logic [7:0] expected, input bit stray);
        if (p) begin req1 = 1'b1; a1 = a; b1 = b; end
        else   begin req0 = 1'b1; a0 = a; b0 = b; end
        tick();
        check_output("gnt0 capture", gnt0, 8'(!p));
        check_output("gnt1 capture", gnt1, 8'(p));
        check_output("busy capture", busy, 8'd1);
        check_output("done capture", done, 8'd0);
        req0 = 1'b0; req1 = 1'b0;
        a0 = ~a0; b0 = ~b0; a1 = ~a1; b1 = ~b1;
        if (stray) ack = 1'b1;
        tick();
        check_output("gnt0 pulse end", gnt0, 8'd0);
        check_output("gnt1 pulse end", gnt1, 8'd0);
        tick();
        tick();
        check_output("done early", done, 8'd0);
        check_output("product early", product, 8'd0);
        ack = 1'b0;
        tick();
        check_output("done", done, 8'd1);
        check_output("product", product, expected);
        check_output("done_id", done_id, 8'(p));
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_idle("after ack");
    endtask

    // Both ports ask together; check who wins, run it to completion, ack.
    task automatic contend(input bit expected_winner, input logic [7:0] expected_product);
        req0 = 1'b1; a0 = 4'd6; b0 = 4'd7;
        req1 = 1'b1; a1 = 4'd9; b1 = 4'd2;
        tick();
        check_output("contend gnt0", gnt0, 8'(!expected_winner));
        check_output("contend gnt1", gnt1, 8'(expected_winner));
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) tick();
        check_output("contend done_id", done_id, 8'(expected_winner));
        check_output("contend product", product, expected_product);
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; ack = 1'b0;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        #12;
        check_idle("reset");
        tick();
        rst_n = 1'b1;

        $display("[TB] single request 13*11");
        apply_stimulus(1'b0, 4'd13, 4'd11, 8'd143, 1'b0);

        $display("[TB] simultaneous requests from reset");
        rst_n = 1'b0;
        #1;
        tick();
        rst_n = 1'b1;
        req0 = 1'b1; a0 = 4'd15; b0 = 4'd15;
        req1 = 1'b1; a1 = 4'd2;  b1 = 4'd3;
        tick();
        check_output("sim gnt0", gnt0, 8'd1);
        check_output("sim gnt1", gnt1, 8'd0);
        req0 = 1'b0;
        repeat (4) tick();
        check_output("sim product0", product, 8'd225);
        check_output("sim done_id0", done_id, 8'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_output("sim no grant on ack edge", gnt1, 8'd0);
        check_output("sim idle after ack", busy, 8'd0);
        tick();
        check_output("sim gnt1 next", gnt1, 8'd1);
        req1 = 1'b0;
        repeat (4) tick();
        check_output("sim product1", product, 8'd6);
        check_output("sim done_id1", done_id, 8'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        contend(1'b0, 8'd42);
        contend(1'b1, 8'd18);
        contend(1'b0, 8'd42);

        $display("[TB] late ack");
        req0 = 1'b1; a0 = 4'd7; b0 = 4'd9;
        tick();
        req0 = 1'b0;
        repeat (4) tick();
        req1 = 1'b1; a1 = 4'd4; b1 = 4'd4;
        for (int i = 0; i < 10; i++) begin
            check_output("late done",    done,    8'd1);
            check_output("late product", product, 8'd63);
            check_output("late done_id", done_id, 8'd0);
            check_output("late gnt0",    gnt0,    8'd0);
            check_output("late gnt1",    gnt1,    8'd0);
            check_output("late busy",    busy,    8'd1);
            tick();
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_output("late back to idle", busy, 8'd0);
        tick();
        check_output("late pending gnt1", gnt1, 8'd1);
        req1 = 1'b0;
        repeat (4) tick();
        check_output("late product1", product, 8'd16);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        $display("[TB] zero and extreme operands");
        apply_stimulus(1'b0, 4'd0, 4'd9,  8'd0,  1'b0);
        apply_stimulus(1'b1, 4'd1, 4'd15, 8'd15, 1'b0);
        apply_stimulus(1'b0, 4'd8, 4'd8,  8'd64, 1'b0);
        apply_stimulus(1'b1, 4'd15, 4'd0, 8'd0,  1'b0);

        $display("[TB] reset mid-operation");
        req0 = 1'b1; a0 = 4'd5; b0 = 4'd5;
        tick();
        req0 = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("mid reset");
        tick();
        tick();
        check_idle("held reset");
        rst_n = 1'b1;
        req1 = 1'b1; a1 = 4'd3; b1 = 4'd5;
        tick();
        check_output("post reset gnt1", gnt1, 8'd1);
        req1 = 1'b0;
        repeat (4) tick();
        check_output("post reset product", product, 8'd15);
        check_output("post reset done_id", done_id, 8'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;

        $display("[TB] stray ack");
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_output("stray idle busy", busy, 8'd0);
        apply_stimulus(1'b0, 4'd12, 4'd10, 8'd120, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
